// File: rtl/fp8_con_pkg.sv
// fp8_con_pkg: shared types and constants for the fp8 converter scheduler
package fp8_con_pkg;
  localparam logic [4:0] TYPE_FP8 = 5'd2;
  localparam logic [4:0] TYPE_FP4 = 5'd6;
  localparam logic [2:0] SUB_E5M2 = 3'd0;
  localparam logic [2:0] SUB_E4M3 = 3'd1;
  typedef struct packed {
    logic [2:0] id;
    logic [1:0] beats;
  } cvt_tag_t;
endpackage

// File: rtl/fp8_con_tag_fifo.sv
// fp8_con_tag_fifo: synchronous FIFO of issue tags (id, beats)
// Ports: push/din write, pop/dout read (dout is the head), count/full/empty status.
module fp8_con_tag_fifo
  import fp8_con_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  cvt_tag_t                 din,
  input  logic                     pop,
  output cvt_tag_t                 dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  cvt_tag_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fp8_con_sched.sv
// fp8_con_sched: round-robin scheduler sharing one to_fp8_con converter between requesters
// Ports: req_* requester side, cvt_* converter side (issue slot out, beats in),
// rsp_* tagged response beats, err_o sticky spurious-beat flag, perf_* counters.
// Optional: FP8_SCHED_PERF_CNT_EN enables the issue/stall counters, else they read 0.
module fp8_con_sched
  import fp8_con_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IN_W      = 512,
  parameter int OUT_W     = 36,
  parameter int TAG_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*5-1:0]       req_type_ab_i,
  input  logic [NUM_REQ*3-1:0]       req_type_ab_sub_i,
  input  logic [NUM_REQ*IN_W-1:0]    req_a_i,
  input  logic [NUM_REQ*IN_W-1:0]    req_b_i,
  output logic                       cvt_in_valid_o,
  input  logic                       cvt_in_ready_i,
  output logic [4:0]                 cvt_type_ab_o,
  output logic [2:0]                 cvt_type_ab_sub_o,
  output logic [IN_W-1:0]            cvt_a_o,
  output logic [IN_W-1:0]            cvt_b_o,
  input  logic                       cvt_out_valid_i,
  output logic                       cvt_out_ready_o,
  input  logic [OUT_W-1:0]           cvt_a_i,
  input  logic [OUT_W-1:0]           cvt_b_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic                       rsp_last_o,
  output logic [OUT_W-1:0]           rsp_a_o,
  output logic [OUT_W-1:0]           rsp_b_o,
  output logic                       err_o,
  output logic [31:0]                perf_issue_cnt_o,
  output logic [31:0]                perf_stall_cnt_o
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TAG_DEPTH) + 1;
  logic [IDW-1:0] rr_ptr, gnt_idx;
  logic           found, grant, in_hs, rsp_hs, pop, beat_cnt;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  tag_cnt;
  logic [4:0]     sel_type;
  cvt_tag_t       head, push_tag;
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!found && req_valid_i[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found   = 1'b1;
        gnt_idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      end
  end
  assign in_hs       = cvt_in_valid_o && cvt_in_ready_i;
  // a pop in the same cycle never frees a slot for this grant
  assign grant       = found && (!cvt_in_valid_o || cvt_in_ready_i) && !fifo_full;
  assign req_ready_o = grant ? NUM_REQ'(1) << gnt_idx : '0;
  assign sel_type    = req_type_ab_i[gnt_idx*5 +: 5];
  assign push_tag    = '{id: 3'(gnt_idx), beats: sel_type == TYPE_FP4 ? 2'd2 : 2'd1};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr            <= '0;
      cvt_in_valid_o    <= 1'b0;
      cvt_type_ab_o     <= '0;
      cvt_type_ab_sub_o <= '0;
      cvt_a_o           <= '0;
      cvt_b_o           <= '0;
    end else if (grant) begin
      rr_ptr            <= gnt_idx == IDW'(NUM_REQ - 1) ? '0 : gnt_idx + IDW'(1);
      cvt_in_valid_o    <= 1'b1;
      cvt_type_ab_o     <= sel_type;
      cvt_type_ab_sub_o <= req_type_ab_sub_i[gnt_idx*3 +: 3];
      cvt_a_o           <= req_a_i[gnt_idx*IN_W +: IN_W];
      cvt_b_o           <= req_b_i[gnt_idx*IN_W +: IN_W];
    end else if (in_hs) begin
      cvt_in_valid_o    <= 1'b0;
    end
  end
  fp8_con_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant),
    .din   (push_tag),
    .pop   (pop),
    .dout  (head),
    .count (tag_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  // with no tag outstanding the converter beat is swallowed and flagged
  assign rsp_valid_o     = cvt_out_valid_i && !fifo_empty;
  assign cvt_out_ready_o = rsp_ready_i || fifo_empty;
  assign rsp_a_o         = cvt_a_i;
  assign rsp_b_o         = cvt_b_i;
  assign rsp_id_o        = IDW'(head.id);
  assign rsp_last_o      = {1'b0, beat_cnt} == head.beats - 2'd1;
  assign rsp_hs          = rsp_valid_o && rsp_ready_i;
  assign pop             = rsp_hs && rsp_last_o;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      if (rsp_hs) beat_cnt <= rsp_last_o ? 1'b0 : 1'b1;
      if (cvt_out_valid_i && fifo_empty) err_o <= 1'b1;
    end
  end
`ifdef FP8_SCHED_PERF_CNT_EN
  logic [31:0] issue_cnt, stall_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      issue_cnt <= issue_cnt + 32'(in_hs);
      stall_cnt <= stall_cnt + 32'(|req_valid_i && !grant);
    end
  end
  assign perf_issue_cnt_o = issue_cnt;
  assign perf_stall_cnt_o = stall_cnt;
`else
  assign perf_issue_cnt_o = 32'd0;
  assign perf_stall_cnt_o = 32'd0;
`endif
endmodule
